// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction width and the sequential PC step.
package fetch_pkg;

  // Width of one instruction word returned by instruction memory.
  localparam int INSTR_WIDTH = 32;

  // Byte distance between consecutive sequential instructions.
  localparam int PC_INCR = 4;

  // Fetch FSM states.
  //   ST_REQ   : presenting a request for the instruction at pc_in
  //   ST_WAIT  : one request accepted, waiting for its response
  //   ST_HOLD  : instruction captured, offering it to decode
  //   ST_DRAIN : a redirect orphaned an accepted request; swallow its response
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // Force a redirect target onto an instruction boundary (clear the low two bits).
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    align_word = {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit. It issues one instruction-memory request at a time
// for the address held in an external program counter register, captures the
// response and offers it to decode. It computes the PC register's next value
// every cycle, so the external register closes the pc_next_out -> pc_in loop.
//
// Handshakes: every valid/ready pair transfers exactly on a rising clk_in edge
// where valid and ready are both high. A producer never withdraws valid or
// changes its payload while it waits for ready. The only exception is a
// redirect, which cancels whatever is in flight. Memory responses have no ready:
// imem_rsp_valid_in is high for exactly one cycle for each accepted request.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH_POW = 6,
  parameter int ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter int INSTR_WIDTH    = fetch_pkg::INSTR_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   reset,
  // Program counter loop
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic [ADDR_WIDTH-1:0]  pc_next_out,
  // Instruction memory request channel
  output logic                   imem_req_valid_out,
  input  logic                   imem_req_ready_in,
  output logic [ADDR_WIDTH-1:0]  imem_addr_out,
  // Instruction memory response channel
  input  logic                   imem_rsp_valid_in,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data_in,
  // Decode channel
  output logic                   fetch_valid_out,
  input  logic                   fetch_ready_in,
  output logic [INSTR_WIDTH-1:0] fetch_instr_out,
  output logic [ADDR_WIDTH-1:0]  fetch_pc_out,
  // Control flow change
  input  logic                   redirect_in,
  input  logic [ADDR_WIDTH-1:0]  redirect_target_in,
  // Current FSM state, for observation only
  output fetch_state_e           dbg_state_out
);

  fetch_state_e           r_state;
  fetch_state_e           w_state_next;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_instr_pc;

  logic                   w_req_valid;
  logic                   w_req_fire;
  logic                   w_capture;
  logic [ADDR_WIDTH-1:0]  w_target_aligned;
  logic [ADDR_WIDTH-1:0]  w_pc_seq;

  // Redirect targets land on an instruction boundary.
  assign w_target_aligned = {redirect_target_in[ADDR_WIDTH-1:2], 2'b00};

  // Sequential successor; the addition wraps at the top of the address space.
  assign w_pc_seq = pc_in + ADDR_WIDTH'(PC_INCR);

  // A request goes out only in REQ, and never while reset holds the block idle.
  assign w_req_valid = (r_state == ST_REQ) && !reset;
  assign w_req_fire  = w_req_valid && imem_req_ready_in;

  // A response is kept only when it is the answer to a live request, that is,
  // in WAIT with no redirect in the same cycle.
  assign w_capture = (r_state == ST_WAIT) && imem_rsp_valid_in && !redirect_in && !reset;

  // Next FSM state: at most one request outstanding, and redirects cancel in-flight work.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_REQ: begin
        // An accepted request cannot be withdrawn; a redirect that arrives
        // together with acceptance has to wait out the stale response.
        if (w_req_fire) w_state_next = redirect_in ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_in) w_state_next = imem_rsp_valid_in ? ST_REQ : ST_DRAIN;
        else if (imem_rsp_valid_in) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        // A redirect kills the held instruction even if decode is ready now.
        if (redirect_in || fetch_ready_in) w_state_next = ST_REQ;
      end
      ST_DRAIN: begin
        // Once the stale response has arrived nothing is in flight. A redirect
        // in the same cycle is already reflected in pc_next_out, so the next
        // request uses its target.
        if (imem_rsp_valid_in) w_state_next = ST_REQ;
      end
      default: w_state_next = ST_REQ;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk_in) begin
    if (reset) r_state <= ST_REQ;
    else       r_state <= w_state_next;
  end

  // Instruction holding register: it loads only on a kept response and
  // otherwise stays stable while decode stalls.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= imem_rsp_data_in;
      r_instr_pc <= pc_in;
    end
  end

  // Next PC: reset, then redirect, then sequential step on a kept response, else hold.
  always_comb begin
    pc_next_out = pc_in;
    if (reset)                                              pc_next_out = '0;
    else if (redirect_in)                                   pc_next_out = w_target_aligned;
    else if ((r_state == ST_WAIT) && imem_rsp_valid_in)     pc_next_out = w_pc_seq;
  end

  assign imem_req_valid_out = w_req_valid;
  assign imem_addr_out      = pc_in;
  assign fetch_valid_out    = (r_state == ST_HOLD) && !reset;
  assign fetch_instr_out    = r_instr;
  assign fetch_pc_out       = r_instr_pc;
  assign dbg_state_out      = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. It models the external PC register and
// drives memory and decode handshakes step by step.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int AW = 64;
  localparam int IW = 32;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_q = '0;
  logic [AW-1:0] pc_next_out;
  logic          imem_req_valid_out;
  logic          imem_req_ready_in;
  logic [AW-1:0] imem_addr_out;
  logic          imem_rsp_valid_in;
  logic [IW-1:0] imem_rsp_data_in;
  logic          fetch_valid_out;
  logic          fetch_ready_in;
  logic [IW-1:0] fetch_instr_out;
  logic [AW-1:0] fetch_pc_out;
  logic          redirect_in;
  logic [AW-1:0] redirect_target_in;
  fetch_state_e  dbg_state_out;

  int checks   = 0;
  int failures = 0;

  instr_fetch dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .pc_in              (pc_q),
    .pc_next_out        (pc_next_out),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_addr_out      (imem_addr_out),
    .imem_rsp_valid_in  (imem_rsp_valid_in),
    .imem_rsp_data_in   (imem_rsp_data_in),
    .fetch_valid_out    (fetch_valid_out),
    .fetch_ready_in     (fetch_ready_in),
    .fetch_instr_out    (fetch_instr_out),
    .fetch_pc_out       (fetch_pc_out),
    .redirect_in        (redirect_in),
    .redirect_target_in (redirect_target_in),
    .dbg_state_out      (dbg_state_out)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // External program counter register
  always @(posedge clk_in) pc_q <= pc_next_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  // Let combinational outputs settle after the inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready_in  = 1'b0;
    imem_rsp_valid_in  = 1'b0;
    imem_rsp_data_in   = '0;
    fetch_ready_in     = 1'b0;
    redirect_in        = 1'b0;
    redirect_target_in = '0;
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    idle_inputs();
    settle();
    check("rst_pc_next", pc_next_out, 0);
    check("rst_req_valid", imem_req_valid_out, 0);
    check("rst_fetch_valid", fetch_valid_out, 0);
    tick();
    tick();
    check("rst_instr", fetch_instr_out, 0);
    check("rst_fpc", fetch_pc_out, 0);
    check("rst_state", dbg_state_out, ST_REQ);
    reset = 1'b0;

    // Back-to-back fetch of mem[0] and mem[4]
    imem_req_ready_in = 1'b1;
    settle();
    check("f0_req_valid", imem_req_valid_out, 1);
    check("f0_addr", imem_addr_out, 0);
    check("f0_pc_next", pc_next_out, 0);
    tick();
    imem_req_ready_in = 1'b0;
    imem_rsp_valid_in = 1'b1;
    imem_rsp_data_in  = 32'h0000_0013;
    settle();
    check("f0_wait_state", dbg_state_out, ST_WAIT);
    check("f0_wait_req_valid", imem_req_valid_out, 0);
    check("f0_pc_incr", pc_next_out, 4);
    tick();
    imem_rsp_valid_in = 1'b0;
    fetch_ready_in    = 1'b1;
    settle();
    check("f0_valid", fetch_valid_out, 1);
    check("f0_instr", fetch_instr_out, 32'h0000_0013);
    check("f0_fpc", fetch_pc_out, 0);
    tick();
    fetch_ready_in    = 1'b0;
    imem_req_ready_in = 1'b1;
    settle();
    check("f1_addr", imem_addr_out, 4);
    check("f1_req_valid", imem_req_valid_out, 1);
    tick();
    imem_req_ready_in = 1'b0;
    imem_rsp_valid_in = 1'b1;
    imem_rsp_data_in  = 32'h0050_0093;
    settle();
    check("f1_pc_incr", pc_next_out, 8);
    tick();
    imem_rsp_valid_in = 1'b0;
    settle();
    check("f1_instr", fetch_instr_out, 32'h0050_0093);
    check("f1_fpc", fetch_pc_out, 4);

    // Decode stalls for 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", fetch_valid_out, 1);
      check("stall_instr", fetch_instr_out, 32'h0050_0093);
      check("stall_fpc", fetch_pc_out, 4);
      check("stall_no_req", imem_req_valid_out, 0);
      check("stall_pc_next", pc_next_out, 8);
      tick();
      settle();
    end
    fetch_ready_in = 1'b1;
    tick();
    fetch_ready_in = 1'b0;
    settle();
    check("stall_release_addr", imem_addr_out, 8);

    // Redirect to 0x103 in WAIT, stale response two cycles later
    imem_req_ready_in = 1'b1;
    tick();
    imem_req_ready_in  = 1'b0;
    redirect_in        = 1'b1;
    redirect_target_in = 64'h103;
    settle();
    check("rw_pc_next", pc_next_out, 64'h100);
    tick();
    redirect_in = 1'b0;
    settle();
    check("rw_drain_state", dbg_state_out, ST_DRAIN);
    check("rw_drain_req", imem_req_valid_out, 0);
    check("rw_drain_pc_next", pc_next_out, 64'h100);
    tick();
    imem_rsp_valid_in = 1'b1;
    imem_rsp_data_in  = 32'hDEAD_BEEF;
    settle();
    check("rw_drain_fvalid", fetch_valid_out, 0);
    check("rw_drain_rsp_pc", pc_next_out, 64'h100);
    tick();
    imem_rsp_valid_in = 1'b0;
    settle();
    check("rw_req_state", dbg_state_out, ST_REQ);
    check("rw_req_addr", imem_addr_out, 64'h100);
    check("rw_instr_kept", fetch_instr_out, 32'h0050_0093);

    // Redirect together with the response in WAIT
    imem_req_ready_in = 1'b1;
    tick();
    imem_req_ready_in  = 1'b0;
    imem_rsp_valid_in  = 1'b1;
    imem_rsp_data_in   = 32'h0000_BEEF;
    redirect_in        = 1'b1;
    redirect_target_in = 64'h200;
    settle();
    check("rr_pc_next", pc_next_out, 64'h200);
    tick();
    imem_rsp_valid_in = 1'b0;
    redirect_in       = 1'b0;
    settle();
    check("rr_state", dbg_state_out, ST_REQ);
    check("rr_fvalid", fetch_valid_out, 0);
    check("rr_addr", imem_addr_out, 64'h200);
    check("rr_instr_kept", fetch_instr_out, 32'h0050_0093);

    // Redirect together with request acceptance goes to DRAIN
    imem_req_ready_in  = 1'b1;
    redirect_in        = 1'b1;
    redirect_target_in = 64'h300;
    tick();
    imem_req_ready_in = 1'b0;
    redirect_in       = 1'b0;
    imem_rsp_valid_in = 1'b1;
    settle();
    check("rq_drain_state", dbg_state_out, ST_DRAIN);
    tick();
    imem_rsp_valid_in = 1'b0;
    settle();
    check("rq_addr", imem_addr_out, 64'h300);

    // Redirect in HOLD with decode ready: instruction is not transferred
    imem_req_ready_in = 1'b1;
    tick();
    imem_req_ready_in = 1'b0;
    imem_rsp_valid_in = 1'b1;
    imem_rsp_data_in  = 32'h1111_1111;
    tick();
    imem_rsp_valid_in = 1'b0;
    settle();
    check("rh_fpc", fetch_pc_out, 64'h300);
    fetch_ready_in     = 1'b1;
    redirect_in        = 1'b1;
    redirect_target_in = 64'h400;
    settle();
    check("rh_pc_next", pc_next_out, 64'h400);
    tick();
    fetch_ready_in = 1'b0;
    redirect_in    = 1'b0;
    settle();
    check("rh_fvalid", fetch_valid_out, 0);
    check("rh_addr", imem_addr_out, 64'h400);

    // Redirect in REQ without acceptance, then wrap at the top of the address space
    redirect_in        = 1'b1;
    redirect_target_in = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_in = 1'b0;
    settle();
    check("wrap_state", dbg_state_out, ST_REQ);
    check("wrap_addr", imem_addr_out, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready_in = 1'b1;
    tick();
    imem_req_ready_in = 1'b0;
    imem_rsp_valid_in = 1'b1;
    imem_rsp_data_in  = 32'h2222_2222;
    settle();
    check("wrap_pc_next", pc_next_out, 0);
    tick();
    imem_rsp_valid_in = 1'b0;
    settle();
    check("wrap_fpc", fetch_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", fetch_instr_out, 32'h2222_2222);
    fetch_ready_in = 1'b1;
    tick();
    fetch_ready_in = 1'b0;
    settle();
    check("wrap_next_addr", imem_addr_out, 0);

    // Reset while waiting for a response
    imem_req_ready_in = 1'b1;
    tick();
    imem_req_ready_in = 1'b0;
    reset = 1'b1;
    settle();
    check("rw2_pre_state", dbg_state_out, ST_WAIT);
    check("rw2_pc_next", pc_next_out, 0);
    check("rw2_req_valid", imem_req_valid_out, 0);
    check("rw2_fvalid", fetch_valid_out, 0);
    tick();
    reset = 1'b0;
    settle();
    check("rw2_state", dbg_state_out, ST_REQ);
    check("rw2_instr", fetch_instr_out, 0);
    check("rw2_fpc", fetch_pc_out, 0);
    check("rw2_req_valid_after", imem_req_valid_out, 1);
    check("rw2_addr", imem_addr_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_WIDTH_POW SHALL default to 6 and set the address width as a power of two.
REQ-002 Parameter ADDR_WIDTH SHALL default to 1 << ADDR_WIDTH_POW and be the PC and memory address width.
REQ-003 Parameter INSTR_WIDTH SHALL default to 32 and be the instruction width.
REQ-004 clk_in  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc_in  input  ADDR_WIDTH  current PC from the program counter register.
REQ-007 pc_next_out  output  ADDR_WIDTH  next PC, driven to the program counter register's next-instruction input every cycle.
REQ-008 imem_req_valid_out  output  1  instruction memory request valid.
REQ-009 imem_req_ready_in  input  1  instruction memory accepts request.
REQ-010 imem_addr_out  output  ADDR_WIDTH  request address.
REQ-011 imem_rsp_valid_in  input  1  response valid, one cycle per accepted request.
REQ-012 imem_rsp_data_in  input  INSTR_WIDTH  response instruction word.
REQ-013 fetch_valid_out  output  1  instruction available to decode.
REQ-014 fetch_ready_in  input  1  decode accepts instruction.
REQ-015 fetch_instr_out  output  INSTR_WIDTH  held instruction.
REQ-016 fetch_pc_out  output  ADDR_WIDTH  address of the held instruction.
REQ-017 redirect_in  input  1  branch/jump redirect pulse.
REQ-018 redirect_target_in  input  ADDR_WIDTH  redirect target.

Function
REQ-019 The FSM SHALL have states REQ, WAIT, HOLD, DRAIN; at most one memory request SHALL be outstanding.
REQ-020 REQ: imem_req_valid_out=1, imem_addr_out=pc_in; on valid&ready, go to WAIT; otherwise stay.
REQ-021 WAIT: on imem_rsp_valid_in, capture imem_rsp_data_in into fetch_instr_out and pc_in into fetch_pc_out, then go to HOLD.
REQ-022 HOLD: fetch_valid_out=1; on fetch_ready_in, go to REQ; the outputs SHALL stay stable while ready is low.
REQ-023 pc_next_out SHALL be computed combinationally with this priority:
- redirect_in: {redirect_target_in[ADDR_WIDTH-1:2], 2'b00}.
- else, response capture in WAIT: pc_in + 4, modulo 2^ADDR_WIDTH (wrap-around).
- else: pc_in.
REQ-024 Minimum throughput SHALL be one instruction per 3 cycles with zero-wait memory and decode.
REQ-025 Redirect in REQ without handshake SHALL stay in REQ; the next request SHALL use the target.
REQ-026 Redirect in REQ with a same-cycle handshake SHALL go to DRAIN.
REQ-027 Redirect in WAIT without a response SHALL go to DRAIN.
REQ-028 Redirect in WAIT with a same-cycle response SHALL discard the response and go to REQ.
REQ-029 Redirect in HOLD SHALL drop fetch_valid_out from the next cycle, go to REQ, and never transfer the held instruction, even if fetch_ready_in is high.
REQ-030 DRAIN SHALL discard the response and go to REQ on imem_rsp_valid_in; fetch_valid_out=0 and imem_req_valid_out=0.
REQ-031 A redirect in DRAIN SHALL update pc_next_out and keep the state DRAIN.
REQ-032 imem_req_valid_out SHALL be 0 in WAIT, HOLD and DRAIN.

Reset
REQ-033 While reset is high: state SHALL become REQ; pc_next_out, imem_req_valid_out and fetch_valid_out SHALL be 0; fetch_instr_out and fetch_pc_out SHALL clear to 0 on the edge.
REQ-034 Reset mid-transaction SHALL abandon any outstanding request; memory SHALL be reset together with this block.
REQ-035 The first request after reset SHALL target address 0.

Structure
REQ-036 Package fetch_pkg SHALL hold the FSM state enum, INSTR_WIDTH and the constant PC_INCR=4.
REQ-037 The block SHALL be a single module with no sub-module; the program counter register SHALL stay external and close the pc_next_out -> pc_in loop.

Verification
REQ-038 Reset, then ready/rsp always 1 with mem[0]=0x00000013 and mem[4]=0x00500093 -> fetch_pc_out 0 then 4, those instructions in order, one per 3 cycles.
REQ-039 fetch_ready_in held low 5 cycles in HOLD -> fetch_instr_out/fetch_pc_out stable, no new request, pc_next_out=pc_in.
REQ-040 Redirect to 0x103 in WAIT, response 2 cycles later -> response dropped, next request address 0x100.
REQ-041 Redirect same cycle as rsp_valid in WAIT -> no fetch_valid_out, next request at target.
REQ-042 pc_in=2^ADDR_WIDTH-4, response captured -> pc_next_out=0.
REQ-043 Reset asserted in WAIT -> outputs 0, then first request at address 0.
